// File: rtl/serial_alu_digit_pkg.sv
// Shared op codes, FSM encoding and Booth-pair decode for the digit-serial ALU.
package serial_alu_digit_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_BOOTH = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_PASS  = 4'd6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // A Booth step on pair q1q0 either subtracts, adds or leaves the partial product alone.
    function automatic logic [3:0] booth_decode(input logic q1, input logic q0);
        logic [3:0] eff;
        case ({q1, q0})
            2'b10:   eff = OP_SUB;
            2'b01:   eff = OP_ADD;
            default: eff = OP_PASS;
        endcase
        return eff;
    endfunction

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_PASS;
    endfunction

endpackage

// File: rtl/serial_alu_digit_if.sv
// Handshake and digit bus between the serialisers/controller (master) and the ALU (slave).
interface serial_alu_digit_if #(parameter int DIGIT = 1);

    logic             start;
    logic [3:0]       op;
    logic             q1;
    logic             q0;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic             busy;
    logic [DIGIT-1:0] res_dig;
    logic             res_valid;
    logic             done;
    logic             carry;
    logic             ovf;
    logic             zero;
    logic             illegal;

    modport master (
        output start, op, q1, q0, a_dig, b_dig,
        input  busy, res_dig, res_valid, done, carry, ovf, zero, illegal
    );

    modport slave (
        input  start, op, q1, q0, a_dig, b_dig,
        output busy, res_dig, res_valid, done, carry, ovf, zero, illegal
    );

endinterface

// File: rtl/serial_alu_digit_slice.sv
// Combinational DIGIT-wide slice: ripple add/sub plus bitwise logic and pass-through.
module serial_alu_digit_slice
    import serial_alu_digit_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             cin_i,
    input  logic [3:0]       eff_op_i,
    output logic [DIGIT-1:0] res_o,
    output logic             cout_o,
    output logic             c_msb_in_o
);

    logic [DIGIT-1:0] bEff;
    logic [DIGIT-1:0] sum;
    logic             c;
    logic             cMsb;

    // Subtraction reuses the adder with inverted B; the +1 comes in through the preset carry.
    always_comb begin
        bEff = (eff_op_i == OP_SUB) ? ~b_i : b_i;
        sum  = '0;
        c    = cin_i;
        cMsb = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i] = a_i[i] ^ bEff[i] ^ c;
            if (i == DIGIT - 1) cMsb = c;
            c = (a_i[i] & bEff[i]) | (c & (a_i[i] ^ bEff[i]));
        end

        res_o      = a_i;
        cout_o     = 1'b0;
        c_msb_in_o = 1'b0;
        case (eff_op_i)
            OP_ADD, OP_SUB: begin
                res_o      = sum;
                cout_o     = c;
                c_msb_in_o = cMsb;
            end
            OP_AND:  res_o = a_i & b_i;
            OP_OR:   res_o = a_i | b_i;
            OP_XOR:  res_o = a_i ^ b_i;
            default: res_o = a_i;
        endcase
    end

endmodule

// File: rtl/serial_alu_digit.sv
// Digit-serial ALU: LSB-first operands, DIGIT bits per cycle, start/busy/done handshake
// with end-of-op carry, overflow and zero flags.
module serial_alu_digit
    import serial_alu_digit_pkg::*;
#(
    parameter int LENGTH = 32,
    parameter int DIGIT  = 1
) (
    input  logic                clk,
    input  logic                reset,
    serial_alu_digit_if.slave   bus
);

    localparam int NDIG = LENGTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [3:0]       effOp_q;
    logic             cy_q;
    logic             zacc_q;
    logic [DIGIT-1:0] res_q;
    logic             resValid_q, done_q, illegal_q;
    logic             carry_q, ovf_q, zero_q;

    logic             accept, illegalStart, lastDig, busy;
    logic [3:0]       effStart;
    logic [DIGIT-1:0] sliceRes;
    logic             sliceCout, sliceCmsb;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)  state_d = RUN;
            RUN:     if (lastDig) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Booth pairs are resolved at start so the slice only ever sees ADD, SUB or PASS.
    always_comb begin
        busy         = (state_q == RUN);
        accept       = (state_q == IDLE) && bus.start && op_legal(bus.op);
        illegalStart = (state_q == IDLE) && bus.start && !op_legal(bus.op);
        lastDig      = busy && (cnt_q == LAST);
        effStart     = (bus.op == OP_BOOTH) ? booth_decode(bus.q1, bus.q0) : bus.op;
    end

    serial_alu_digit_slice #(.DIGIT(DIGIT)) u_slice (
        .a_i        (bus.a_dig),
        .b_i        (bus.b_dig),
        .cin_i      (cy_q),
        .eff_op_i   (effOp_q),
        .res_o      (sliceRes),
        .cout_o     (sliceCout),
        .c_msb_in_o (sliceCmsb)
    );

    // Flags are only written on the last digit and cleared on the next accepted start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q      <= '0;
            effOp_q    <= OP_ADD;
            cy_q       <= 1'b0;
            zacc_q     <= 1'b0;
            res_q      <= '0;
            resValid_q <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            resValid_q <= busy;
            done_q     <= lastDig;
            illegal_q  <= illegalStart;
            if (busy) res_q <= sliceRes;
            if (accept) begin
                effOp_q <= effStart;
                cnt_q   <= '0;
                zacc_q  <= 1'b1;
                cy_q    <= (effStart == OP_SUB);
                carry_q <= 1'b0;
                ovf_q   <= 1'b0;
                zero_q  <= 1'b0;
            end else if (busy) begin
                cnt_q  <= cnt_q + CW'(1);
                cy_q   <= sliceCout;
                zacc_q <= zacc_q & (sliceRes == '0);
                if (lastDig) begin
                    carry_q <= sliceCout;
                    ovf_q   <= sliceCout ^ sliceCmsb;
                    zero_q  <= zacc_q & (sliceRes == '0);
                end
            end
        end
    end

    assign bus.busy      = busy;
    assign bus.res_dig   = res_q;
    assign bus.res_valid = resValid_q;
    assign bus.done      = done_q;
    assign bus.carry     = carry_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_serial_alu_digit.sv
// Directed bench: an 8-bit/2-bit-digit ALU driven from a vector table plus hand sequences,
// and a 32-bit/1-bit-digit ALU for the long carry-ripple case.
module tb_serial_alu_digit;
    import serial_alu_digit_pkg::*;

    logic clk;
    logic resetA, resetB;
    int   checks = 0;
    int   errors = 0;

    serial_alu_digit_if #(.DIGIT(2)) ifA ();
    serial_alu_digit_if #(.DIGIT(1)) ifB ();

    serial_alu_digit #(.LENGTH(8), .DIGIT(2)) dutA (
        .clk   (clk),
        .reset (resetA),
        .bus   (ifA)
    );

    serial_alu_digit #(.LENGTH(32), .DIGIT(1)) dutB (
        .clk   (clk),
        .reset (resetB),
        .bus   (ifB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        string      name;
        logic [3:0] op;
        logic       q1;
        logic       q0;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] expRes;
        logic       expCarry;
        logic       expOvf;
        logic       expZero;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic q1, input logic q0);
        ifA.start = 1'b1;
        ifA.op    = op;
        ifA.q1    = q1;
        ifA.q0    = q0;
        @(posedge clk); #1;
    endtask

    // Feeds NDIG=4 digits, collects the result stream and checks the end-of-op outputs.
    task automatic feedA(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] expRes, input logic expC, input logic expO,
                         input logic expZ);
        logic [7:0] got;
        got = '0;
        for (int k = 0; k < 4; k++) begin
            checkOutput({name, " busy"}, 32'(ifA.busy), 32'd1);
            if (k == 0) begin
                checkOutput({name, " carry cleared"}, 32'(ifA.carry), 32'd0);
                checkOutput({name, " zero cleared"}, 32'(ifA.zero), 32'd0);
            end
            ifA.a_dig = a[2*k +: 2];
            ifA.b_dig = b[2*k +: 2];
            @(posedge clk); #1;
            checkOutput({name, " res_valid"}, 32'(ifA.res_valid), 32'd1);
            got[2*k +: 2] = ifA.res_dig;
            if (k < 3) checkOutput({name, " early done"}, 32'(ifA.done), 32'd0);
        end
        checkOutput({name, " done"}, 32'(ifA.done), 32'd1);
        checkOutput({name, " busy at done"}, 32'(ifA.busy), 32'd0);
        checkOutput({name, " result"}, 32'(got), 32'(expRes));
        checkOutput({name, " carry"}, 32'(ifA.carry), 32'(expC));
        checkOutput({name, " ovf"}, 32'(ifA.ovf), 32'(expO));
        checkOutput({name, " zero"}, 32'(ifA.zero), 32'(expZ));
    endtask

    initial begin
        logic [31:0] gotB;
        int          busyCnt;

        vecs[0] = '{"add 7f+01",   OP_ADD,   1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{"sub 05-05",   OP_SUB,   1'b0, 1'b0, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{"sub 03-05",   OP_SUB,   1'b0, 1'b0, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{"booth 10",    OP_BOOTH, 1'b1, 1'b0, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{"booth 01",    OP_BOOTH, 1'b0, 1'b1, 8'h03, 8'h05, 8'h08, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{"booth 11",    OP_BOOTH, 1'b1, 1'b1, 8'h03, 8'h05, 8'h03, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{"or 0f|a0",    OP_OR,    1'b0, 1'b0, 8'h0F, 8'hA0, 8'hAF, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{"pass 00",     OP_PASS,  1'b0, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{"sub 80-01",   OP_SUB,   1'b0, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
        vecs[9] = '{"add ff+01",   OP_ADD,   1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};

        resetA = 1'b0;
        resetB = 1'b0;
        ifA.start = 1'b0; ifA.op = OP_ADD; ifA.q1 = 1'b0; ifA.q0 = 1'b0;
        ifA.a_dig = '0;   ifA.b_dig = '0;
        ifB.start = 1'b0; ifB.op = OP_ADD; ifB.q1 = 1'b0; ifB.q0 = 1'b0;
        ifB.a_dig = '0;   ifB.b_dig = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", 32'(ifA.busy), 32'd0);
        checkOutput("reset res_dig", 32'(ifA.res_dig), 32'd0);
        checkOutput("reset res_valid", 32'(ifA.res_valid), 32'd0);
        checkOutput("reset done", 32'(ifA.done), 32'd0);
        checkOutput("reset flags", 32'({ifA.carry, ifA.ovf, ifA.zero}), 32'd0);
        checkOutput("reset illegal", 32'(ifA.illegal), 32'd0);
        resetA = 1'b1;
        resetB = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].op, vecs[i].q1, vecs[i].q0);
            ifA.start = 1'b0;
            feedA(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].expRes,
                  vecs[i].expCarry, vecs[i].expOvf, vecs[i].expZero);
            @(posedge clk); #1;
            checkOutput({vecs[i].name, " carry hold"}, 32'(ifA.carry), 32'(vecs[i].expCarry));
            checkOutput({vecs[i].name, " zero hold"}, 32'(ifA.zero), 32'(vecs[i].expZero));
            checkOutput({vecs[i].name, " valid drop"}, 32'(ifA.res_valid), 32'd0);
        end

        // Back-to-back: start stays high; the second op is picked up in the done cycle.
        applyStimulus(OP_AND, 1'b0, 1'b0);
        ifA.op = OP_XOR;
        feedA("b2b and", 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        ifA.start = 1'b0;
        feedA("b2b xor", 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("b2b no third op", 32'(ifA.busy), 32'd0);

        applyStimulus(4'd9, 1'b0, 1'b0);
        ifA.start = 1'b0;
        checkOutput("illegal pulse", 32'(ifA.illegal), 32'd1);
        checkOutput("illegal busy", 32'(ifA.busy), 32'd0);
        @(posedge clk); #1;
        checkOutput("illegal clears", 32'(ifA.illegal), 32'd0);
        checkOutput("illegal stays idle", 32'(ifA.busy), 32'd0);

        // Reset in the middle of an ADD after two digits have been taken.
        applyStimulus(OP_ADD, 1'b0, 1'b0);
        ifA.start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ifA.a_dig = 2'b11;
            ifA.b_dig = 2'b01;
            @(posedge clk); #1;
        end
        checkOutput("pre-reset busy", 32'(ifA.busy), 32'd1);
        resetA = 1'b0;
        @(posedge clk); #1;
        checkOutput("midrun reset busy", 32'(ifA.busy), 32'd0);
        checkOutput("midrun reset res_valid", 32'(ifA.res_valid), 32'd0);
        checkOutput("midrun reset res_dig", 32'(ifA.res_dig), 32'd0);
        checkOutput("midrun reset done", 32'(ifA.done), 32'd0);
        resetA = 1'b1;
        @(posedge clk); #1;
        checkOutput("post-reset no done", 32'(ifA.done), 32'd0);
        applyStimulus(OP_ADD, 1'b0, 1'b0);
        ifA.start = 1'b0;
        feedA("post-reset add", 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0);

        // 32-bit ripple through every digit: 0xFFFFFFFF + 1.
        ifB.start = 1'b1;
        ifB.op    = OP_ADD;
        @(posedge clk); #1;
        ifB.start = 1'b0;
        gotB      = 32'hFFFF_FFFF;
        busyCnt   = 0;
        for (int k = 0; k < 32; k++) begin
            if (ifB.busy) busyCnt++;
            ifB.a_dig = 1'b1;
            ifB.b_dig = (k == 0) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            gotB[k] = ifB.res_dig[0];
        end
        checkOutput("w32 busy cycles", 32'(busyCnt), 32'd32);
        checkOutput("w32 busy low", 32'(ifB.busy), 32'd0);
        checkOutput("w32 done", 32'(ifB.done), 32'd1);
        checkOutput("w32 result", gotB, 32'h0000_0000);
        checkOutput("w32 carry", 32'(ifB.carry), 32'd1);
        checkOutput("w32 zero", 32'(ifB.zero), 32'd1);
        checkOutput("w32 ovf", 32'(ifB.ovf), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
